// File: rtl/ddr_fifo_pkg.sv
// ddr_fifo_pkg
//   Shared constants and helpers for the multi-channel DDR command FIFO.
//   C_MAX_CH / C_MAX_DEPTH_WIDTH bound the legal parameter range, and
//   C_MAX_LEVEL_WIDTH is the widest level counter any channel can need.
package ddr_fifo_pkg;

    localparam int unsigned C_MAX_CH          = 8;
    localparam int unsigned C_MAX_DEPTH_WIDTH = 10;
    // A level must hold 0..depth inclusive, hence one bit more than a pointer.
    localparam int unsigned C_MAX_LEVEL_WIDTH = C_MAX_DEPTH_WIDTH + 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_cmd_fifo_ch.sv
// ddr_cmd_fifo_ch
//   One first-word-fall-through command FIFO channel.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     flush             synchronous clear (wins over push/pop in the same cycle)
//     wr_valid/wr_data/wr_ready   producer handshake
//     rd_valid/rd_data/rd_ready   consumer handshake, rd_data registered
//     water_level       stored entries 0..depth
//     almost_full/almost_empty    registered threshold flags
//     overflow          sticky: write attempted while wr_ready=0
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both 1. wr_ready/rd_valid depend only on registered state, never on
//   the opposite-side inputs of the same cycle.
module ddr_cmd_fifo_ch
    import ddr_fifo_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH   = 32,
    parameter int unsigned C_DEPTH_WIDTH  = 4,
    parameter int unsigned C_ALMOST_FULL  = 14,
    parameter int unsigned C_ALMOST_EMPTY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr_valid,
    input  logic [C_DATA_WIDTH-1:0]   wr_data,
    output logic                      wr_ready,
    output logic                      rd_valid,
    output logic [C_DATA_WIDTH-1:0]   rd_data,
    input  logic                      rd_ready,
    output logic [C_DEPTH_WIDTH:0]    water_level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow
);

    localparam int unsigned DEPTH = 1 << C_DEPTH_WIDTH;
    localparam int unsigned LW    = C_DEPTH_WIDTH + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(C_ALMOST_FULL);
    localparam logic [LW-1:0] AE_L    = LW'(C_ALMOST_EMPTY);

    logic [C_DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic [C_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_DEPTH_WIDTH-1:0] rd_ptr_nxt;
    logic [LW-1:0]            level_q, level_d;
    logic [C_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     wr_ready_q, wr_ready_d;
    logic                     almost_full_q, almost_full_d;
    logic                     almost_empty_q, almost_empty_d;
    logic                     overflow_q, overflow_d;
    logic                     push;
    logic                     pop;
    logic                     mem_we;

    always_comb begin
        push       = wr_valid & wr_ready_q;
        pop        = rd_valid_q & rd_ready;
        rd_ptr_nxt = rd_ptr_q + C_DEPTH_WIDTH'(1);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q | (wr_valid & ~wr_ready_q);
        mem_we     = push & ~flush;

        if (push) wr_ptr_d = wr_ptr_q + C_DEPTH_WIDTH'(1);
        if (pop)  rd_ptr_d = rd_ptr_nxt;

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // FWFT head register. On a pop the successor is normally already in
        // memory; the only exception is level 1 with a simultaneous push, where
        // the successor is the word being written this very cycle.
        if (pop) begin
            if (push && (rd_ptr_nxt == wr_ptr_q)) rd_data_d = wr_data;
            else                                  rd_data_d = mem_q[rd_ptr_nxt];
        end else if (push && !rd_valid_q) begin
            rd_data_d = wr_data;
        end

        // Flush discards this cycle's push/pop; rd_data is left as-is since
        // rd_valid drops and the head is meaningless until the next push.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            rd_data_d  = rd_data_q;
            overflow_d = 1'b0;
        end

        rd_valid_d     = (level_d != '0);
        wr_ready_d     = (level_d != DEPTH_L);
        almost_full_d  = (level_d >= AF_L);
        almost_empty_d = (level_d <= AE_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            wr_ready_q     <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            wr_ready_q     <= wr_ready_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
        end
    end

    // Storage has no reset so it maps onto plain distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data;
    end

    assign wr_ready     = wr_ready_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign water_level  = level_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;

endmodule

// File: rtl/ddr_cmd_fifo_mc.sv
// ddr_cmd_fifo_mc
//   Multi-channel single-clock command FIFO feeding the DDR arbiter.
//   C_CH independent FWFT channels; every bus is the per-channel signals
//   concatenated, channel k occupying slice [k*W +: W].
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     flush[C_CH]                 per-channel synchronous clear
//     wr_valid/wr_data/wr_ready   producer handshakes
//     rd_valid/rd_data/rd_ready   consumer handshakes
//     water_level                 C_DEPTH_WIDTH+1 bits per channel
//     almost_full/almost_empty    per-channel threshold flags
//     overflow                    per-channel sticky overflow
module ddr_cmd_fifo_mc
    import ddr_fifo_pkg::*;
#(
    parameter int unsigned C_CH           = 2,
    parameter int unsigned C_DATA_WIDTH   = 32,
    parameter int unsigned C_DEPTH_WIDTH  = 4,
    parameter int unsigned C_ALMOST_FULL  = 14,
    parameter int unsigned C_ALMOST_EMPTY = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [C_CH-1:0]                  flush,
    input  logic [C_CH-1:0]                  wr_valid,
    input  logic [C_CH*C_DATA_WIDTH-1:0]     wr_data,
    output logic [C_CH-1:0]                  wr_ready,
    output logic [C_CH-1:0]                  rd_valid,
    output logic [C_CH*C_DATA_WIDTH-1:0]     rd_data,
    input  logic [C_CH-1:0]                  rd_ready,
    output logic [C_CH*(C_DEPTH_WIDTH+1)-1:0] water_level,
    output logic [C_CH-1:0]                  almost_full,
    output logic [C_CH-1:0]                  almost_empty,
    output logic [C_CH-1:0]                  overflow
);

    localparam int unsigned LW = C_DEPTH_WIDTH + 1;

    for (genvar k = 0; k < C_CH; k++) begin : g_ch
        ddr_cmd_fifo_ch #(
            .C_DATA_WIDTH   (C_DATA_WIDTH),
            .C_DEPTH_WIDTH  (C_DEPTH_WIDTH),
            .C_ALMOST_FULL  (C_ALMOST_FULL),
            .C_ALMOST_EMPTY (C_ALMOST_EMPTY)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush[k]),
            .wr_valid     (wr_valid[k]),
            .wr_data      (wr_data[k*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .wr_ready     (wr_ready[k]),
            .rd_valid     (rd_valid[k]),
            .rd_data      (rd_data[k*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .rd_ready     (rd_ready[k]),
            .water_level  (water_level[k*LW +: LW]),
            .almost_full  (almost_full[k]),
            .almost_empty (almost_empty[k]),
            .overflow     (overflow[k])
        );
    end

endmodule

// File: tb/tb_ddr_cmd_fifo_mc.sv
// Directed bench for ddr_cmd_fifo_mc (2 channels, 32-bit, depth 16).
module tb_ddr_cmd_fifo_mc;

    localparam int CH = 2;
    localparam int W  = 32;
    localparam int DW = 4;
    localparam int LW = DW + 1;
    localparam int DEPTH = 16;

    logic              clk;
    logic              rst_n;
    logic [CH-1:0]     flush;
    logic [CH-1:0]     wr_valid;
    logic [CH*W-1:0]   wr_data;
    logic [CH-1:0]     wr_ready;
    logic [CH-1:0]     rd_valid;
    logic [CH*W-1:0]   rd_data;
    logic [CH-1:0]     rd_ready;
    logic [CH*LW-1:0]  water_level;
    logic [CH-1:0]     almost_full;
    logic [CH-1:0]     almost_empty;
    logic [CH-1:0]     overflow;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Scoreboard: expected rd_data words per channel, in FIFO order.
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // Bench-side reference model of each channel's level and overflow.
    int   mdl_lvl [CH];
    logic mdl_ovf [CH];

    ddr_cmd_fifo_mc #(
        .C_CH(CH), .C_DATA_WIDTH(W), .C_DEPTH_WIDTH(DW),
        .C_ALMOST_FULL(14), .C_ALMOST_EMPTY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .water_level(water_level), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input int k);
        logic [9:0] act;
        logic [9:0] exp;
        act = {water_level[k*LW +: LW], wr_ready[k], rd_valid[k],
               almost_full[k], almost_empty[k], overflow[k]};
        exp = {5'(mdl_lvl[k]), mdl_lvl[k] != DEPTH, mdl_lvl[k] != 0,
               mdl_lvl[k] >= 14, mdl_lvl[k] <= 2, mdl_ovf[k]};
        chk($sformatf("status_ch%0d {lvl,wrdy,rval,af,ae,ovf}", k), 64'(act), 64'(exp));
    endtask

    // ---------------- monitor ----------------
    // Pops happen at the next rising edge; inputs are stable by the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < CH; k++) begin
                if (rd_valid[k] && rd_ready[k] && !flush[k]) begin
                    logic [W-1:0] e;
                    if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk($sformatf("unexpected_pop_ch%0d", k), 64'(rd_data[k*W +: W]), 64'hx);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk($sformatf("rd_data_ch%0d", k), 64'(rd_data[k*W +: W]), 64'(e));
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One clock of stimulus; model updated on the edge, status checked #1 after.
    task automatic step(input logic [1:0] fl, input logic [1:0] wv, input logic [1:0] rr,
                        input logic [W-1:0] d0, input logic [W-1:0] d1);
        flush    = fl;
        wr_valid = wv;
        rd_ready = rr;
        wr_data  = {d1, d0};
        @(posedge clk);
        for (int k = 0; k < CH; k++) begin
            if (fl[k]) begin
                mdl_lvl[k] = 0;
                mdl_ovf[k] = 1'b0;
                if (k == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                logic push_ok;
                logic pop_ok;
                push_ok = wv[k] && (mdl_lvl[k] != DEPTH);
                pop_ok  = rr[k] && (mdl_lvl[k] != 0);
                if (wv[k] && !push_ok) mdl_ovf[k] = 1'b1;
                if (push_ok) begin
                    if (k == 0) exp_q0.push_back(d0); else exp_q1.push_back(d1);
                end
                mdl_lvl[k] = mdl_lvl[k] + int'(push_ok) - int'(pop_ok);
            end
        end
        #1;
        for (int k = 0; k < CH; k++) chk_status(k);
    endtask

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            mdl_lvl[k] = 0;
            mdl_ovf[k] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"},     64'(wr_ready),     64'h3);
        chk({tag, "_rd_valid"},     64'(rd_valid),     64'h0);
        chk({tag, "_rd_data"},      64'(rd_data),      64'h0);
        chk({tag, "_water_level"},  64'(water_level),  64'h0);
        chk({tag, "_almost_full"},  64'(almost_full),  64'h0);
        chk({tag, "_almost_empty"}, 64'(almost_empty), 64'h3);
        chk({tag, "_overflow"},     64'(overflow),     64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        flush = '0; wr_valid = '0; rd_ready = '0; wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Single push on ch0 shows up one cycle later; ch1 stays empty.
        step(2'b00, 2'b01, 2'b00, 32'hA5A5_0001, 32'h0);
        chk("fwft_rd_data_ch0", 64'(rd_data[31:0]), 64'hA5A5_0001);
        step(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);

        // Fill ch0 to full, then one overflowing push, then one pop.
        for (int i = 0; i < 16; i++) step(2'b00, 2'b01, 2'b00, 32'h1000 + i, 32'h0);
        step(2'b00, 2'b01, 2'b00, 32'hBAD0_BAD0, 32'h0);
        step(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
        chk("wr_ready_after_pop_ch0", 64'(wr_ready[0]), 64'h1);
        chk("level_after_pop_ch0", 64'(water_level[0 +: LW]), 64'd15);

        // ch1: reach level 5, then 20 cycles of simultaneous push/pop (wraps).
        for (int i = 0; i < 5; i++) step(2'b00, 2'b10, 2'b00, 32'h0, 32'h2000 + i);
        for (int i = 0; i < 20; i++) step(2'b00, 2'b10, 2'b10, 32'h0, 32'h2100 + i);
        chk("level_steady_ch1", 64'(water_level[LW +: LW]), 64'd5);
        for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 2'b10, 32'h0, 32'h0);

        // ch0: drain to 9 (overflow still set), then flush with push and pop.
        for (int i = 0; i < 6; i++) step(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
        chk("level_before_flush_ch0", 64'(water_level[0 +: LW]), 64'd9);
        step(2'b01, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0);
        chk("flush_clears_ch0", 64'({water_level[0 +: LW], rd_valid[0], overflow[0]}), 64'h0);
        step(2'b00, 2'b01, 2'b00, 32'h5555_0001, 32'h0);
        chk("post_flush_head_ch0", 64'(rd_data[31:0]), 64'h5555_0001);
        step(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);

        // Burst on both channels, then asynchronous reset between edges.
        for (int i = 0; i < 4; i++) step(2'b00, 2'b11, 2'b00, 32'h3000 + i, 32'h4000 + i);
        step(2'b00, 2'b11, 2'b11, 32'h3004, 32'h4004);
        #2;
        rst_n = 1'b0;
        flush = '0; wr_valid = '0; rd_ready = '0;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Traffic after reset.
        step(2'b00, 2'b11, 2'b00, 32'h6000_0001, 32'h7000_0001);
        step(2'b00, 2'b11, 2'b11, 32'h6000_0002, 32'h7000_0002);
        step(2'b00, 2'b00, 2'b11, 32'h0, 32'h0);
        step(2'b00, 2'b00, 2'b11, 32'h0, 32'h0);

        chk("scoreboard_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
